// File: rtl/rib_xbar_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rib_xbar_pkg : FSM encoding and shared constants for the RIB xbar      |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package rib_xbar_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

   localparam logic        RIB_REQ   = 1'b1;
   localparam logic        RIB_NREQ  = 1'b0;
   localparam logic [31:0] ZERO_WORD = 32'h0;

   function automatic int next_idx(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rib_xbar_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rib_xbar_arbiter : fixed-priority / round-robin master picker         |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module rib_xbar_arbiter #(
   parameter int          NUM_M      = 4,
   parameter int          ARB_MODE   = 0,
   parameter logic [31:0] PRIO_ORDER = 32'h1203,
   parameter int          IW         = 2
) (
   input  logic [NUM_M-1:0] req_i,
   input  logic [IW-1:0]    rr_ptr_i,
   output logic             valid_o,
   output logic [IW-1:0]    idx_o
);

   int            cand;
   logic [IW-1:0] cand_idx;

   // Scan from lowest to highest priority so the last hit is the winner.
   always_comb begin
      valid_o  = 1'b0;
      idx_o    = '0;
      cand     = 0;
      cand_idx = '0;
      for (int k = NUM_M - 1; k >= 0; k--) begin
         if (ARB_MODE == 1) cand = (int'(rr_ptr_i) + k) % NUM_M;
         else               cand = int'(PRIO_ORDER[4*k +: 4]);
         cand_idx = IW'(cand);
         if (cand < NUM_M && req_i[cand_idx]) begin
            valid_o = 1'b1;
            idx_o   = cand_idx;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/rib_xbar.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rib_xbar : NUM_M x NUM_S RIB interconnect with wait-state slaves      |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module rib_xbar
   import rib_xbar_pkg::*;
#(
   parameter int             NUM_M      = 4,
   parameter int             NUM_S      = 8,
   parameter int             AW         = 32,
   parameter int             DW         = 32,
   parameter int             SEL_W      = 4,
   parameter logic [NUM_S-1:0] ACK_MASK = 8'h80,
   parameter int             ARB_MODE   = 0,
   parameter logic [31:0]    PRIO_ORDER = 32'h1203,
   parameter int             FETCH_M    = 1,
   parameter int             TIMEOUT    = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_M-1:0]    m_req_i,
   input  logic [NUM_M-1:0]    m_we_i,
   input  logic [NUM_M*AW-1:0] m_addr_i,
   input  logic [NUM_M*DW-1:0] m_data_i,
   output logic [NUM_M*DW-1:0] m_data_o,
   output logic [NUM_M-1:0]    m_ack_o,
   output logic [NUM_S*AW-1:0] s_addr_o,
   output logic [NUM_S*DW-1:0] s_data_o,
   output logic [NUM_S-1:0]    s_we_o,
   output logic [NUM_S-1:0]    s_req_o,
   input  logic [NUM_S*DW-1:0] s_data_i,
   input  logic [NUM_S-1:0]    s_ack_i,
   output logic [2:0]          grant_o,
   output logic                hold_flag_o,
   output logic                err_o
);

   localparam int            IW        = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   localparam int            SW        = (NUM_S > 1) ? $clog2(NUM_S) : 1;
   localparam logic [AW-1:0] ADDR_KEEP = {{SEL_W{1'b0}}, {(AW-SEL_W){1'b1}}};
   localparam logic [7:0]    TMO       = 8'(TIMEOUT);
   localparam logic [IW-1:0] FETCH_IDX = IW'(FETCH_M);

   state_e        state_q, state_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IW-1:0] gnt_q, gnt_d;
   logic [7:0]    wait_cnt_q, wait_cnt_d;
   logic          err_q, err_d;
   logic [SW-1:0] sidx_q, sidx_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          we_q, we_d;

   logic             arb_valid;
   logic [IW-1:0]    arb_idx;
   logic [IW-1:0]    grant_w;
   logic [AW-1:0]    req_addr;
   logic [DW-1:0]    req_wdata;
   logic [SEL_W-1:0] req_sel;
   logic [SW-1:0]    req_sidx;
   logic             req_miss;

   rib_xbar_arbiter #(
      .NUM_M      (NUM_M),
      .ARB_MODE   (ARB_MODE),
      .PRIO_ORDER (PRIO_ORDER),
      .IW         (IW)
   ) u_arbiter (
      .req_i    (m_req_i),
      .rr_ptr_i (rr_ptr_q),
      .valid_o  (arb_valid),
      .idx_o    (arb_idx)
   );

   assign req_addr  = m_addr_i[arb_idx*AW +: AW];
   assign req_wdata = m_data_i[arb_idx*DW +: DW];
   assign req_sel   = req_addr[AW-1 -: SEL_W];
   assign req_sidx  = req_sel[SW-1:0];
   assign req_miss  = int'(req_sel) >= NUM_S;
   assign grant_o   = 3'(grant_w);
   assign err_o     = err_q;

   // Acks are gated by rst so an aborted transfer never reports completion.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      gnt_d       = gnt_q;
      wait_cnt_d  = wait_cnt_q;
      err_d       = 1'b0;
      sidx_d      = sidx_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      we_d        = we_q;
      m_ack_o     = '0;
      m_data_o    = '0;
      s_addr_o    = '0;
      s_data_o    = '0;
      s_we_o      = '0;
      s_req_o     = {NUM_S{RIB_NREQ}};
      grant_w     = gnt_q;
      hold_flag_o = 1'b0;
      if (state_q == IDLE) begin
         if (arb_valid) begin
            grant_w     = arb_idx;
            gnt_d       = arb_idx;
            hold_flag_o = (arb_idx != FETCH_IDX);
            if (req_miss) begin
               m_ack_o[arb_idx] = rst;
               err_d            = 1'b1;
               rr_ptr_d         = IW'(next_idx(int'(arb_idx), NUM_M));
            end else begin
               s_addr_o[req_sidx*AW +: AW] = req_addr & ADDR_KEEP;
               s_data_o[req_sidx*DW +: DW] = req_wdata;
               if (ACK_MASK[req_sidx]) begin
                  state_d    = WAIT;
                  wait_cnt_d = '0;
                  sidx_d     = req_sidx;
                  addr_d     = req_addr & ADDR_KEEP;
                  wdata_d    = req_wdata;
                  we_d       = m_we_i[arb_idx];
               end else begin
                  s_we_o[req_sidx]           = m_we_i[arb_idx];
                  m_ack_o[arb_idx]           = rst;
                  m_data_o[arb_idx*DW +: DW] = s_data_i[req_sidx*DW +: DW];
                  rr_ptr_d                   = IW'(next_idx(int'(arb_idx), NUM_M));
               end
            end
         end
      end else begin
         hold_flag_o               = 1'b1;
         s_req_o[sidx_q]           = RIB_REQ;
         s_we_o[sidx_q]            = we_q;
         s_addr_o[sidx_q*AW +: AW] = addr_q;
         s_data_o[sidx_q*DW +: DW] = wdata_q;
         wait_cnt_d                = wait_cnt_q + 8'd1;
         // A real ack in the timeout cycle takes precedence over the error.
         if (s_ack_i[sidx_q] || wait_cnt_q == TMO) begin
            state_d        = IDLE;
            m_ack_o[gnt_q] = rst;
            rr_ptr_d       = IW'(next_idx(int'(gnt_q), NUM_M));
            if (s_ack_i[sidx_q]) begin
               m_data_o[gnt_q*DW +: DW] = s_data_i[sidx_q*DW +: DW];
            end else begin
               m_data_o[gnt_q*DW +: DW] = DW'(ZERO_WORD);
               err_d                    = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         gnt_q      <= '0;
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
         sidx_q     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         gnt_q      <= gnt_d;
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
         sidx_q     <= sidx_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rib_xbar.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rib_xbar : self-checking bench, fixed-priority and RR instances    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_rib_xbar;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [3:0]   m_req, m_we;
   logic [127:0] m_addr, m_wdata;
   logic [255:0] s_rdata;
   logic [7:0]   s_ack;

   logic [127:0] f_m_data_o, r_m_data_o;
   logic [3:0]   f_m_ack_o, r_m_ack_o;
   logic [255:0] f_s_addr_o, r_s_addr_o, f_s_data_o, r_s_data_o;
   logic [7:0]   f_s_we_o, r_s_we_o, f_s_req_o, r_s_req_o;
   logic [2:0]   f_grant_o, r_grant_o;
   logic         f_hold, r_hold, f_err, r_err;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   rib_xbar #(.ARB_MODE(0)) u_fix (
      .clk(clk), .rst(rst), .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr),
      .m_data_i(m_wdata), .m_data_o(f_m_data_o), .m_ack_o(f_m_ack_o),
      .s_addr_o(f_s_addr_o), .s_data_o(f_s_data_o), .s_we_o(f_s_we_o),
      .s_req_o(f_s_req_o), .s_data_i(s_rdata), .s_ack_i(s_ack),
      .grant_o(f_grant_o), .hold_flag_o(f_hold), .err_o(f_err));

   rib_xbar #(.ARB_MODE(1)) u_rr (
      .clk(clk), .rst(rst), .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr),
      .m_data_i(m_wdata), .m_data_o(r_m_data_o), .m_ack_o(r_m_ack_o),
      .s_addr_o(r_s_addr_o), .s_data_o(r_s_data_o), .s_we_o(r_s_we_o),
      .s_req_o(r_s_req_o), .s_data_i(s_rdata), .s_ack_i(s_ack),
      .grant_o(r_grant_o), .hold_flag_o(r_hold), .err_o(r_err));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; s_ack = '0;
   endtask

   task automatic set_master(input int m, input logic we, input logic [31:0] a, input logic [31:0] d);
      m_req[m] = 1'b1; m_we[m] = we; m_addr[m*32 +: 32] = a; m_wdata[m*32 +: 32] = d;
   endtask

   task automatic fill_sdata();
      for (int s = 0; s < 8; s++) s_rdata[s*32 +: 32] = $urandom;
   endtask

   task automatic do_reset();
      idle_inputs();
      fill_sdata();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      fill_sdata();
      rst = 1'b0;
      step();
      @(negedge clk);
      n_vec++;
      if ({f_m_ack_o, f_s_req_o, f_s_we_o, f_grant_o, f_hold, f_err} !== 26'h0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got ack=%b req=%b we=%b g=%0d hold=%b err=%b, expected all 0",
                  f_m_ack_o, f_s_req_o, f_s_we_o, f_grant_o, f_hold, f_err);
      end
      n_vec++;
      if ({f_m_data_o, f_s_addr_o, f_s_data_o, r_grant_o} !== '0) begin
         n_bad++;
         $display("FAIL reset_data: got mdata=%h grant_rr=%0d, expected 0", f_m_data_o, r_grant_o);
      end
      rst = 1'b1;
   endtask

   task automatic test_fixed_priority();
      logic [31:0] d1;
      do_reset();
      d1 = s_rdata[32 +: 32];
      set_master(0, 1'b0, 32'h1000_0004, 32'h0);
      set_master(3, 1'b0, 32'h1000_0004, 32'h0);
      @(negedge clk);
      n_vec++;
      if ({f_m_ack_o, f_grant_o, f_hold} !== {4'b1000, 3'd3, 1'b1}) begin
         n_bad++;
         $display("FAIL prio_first: got ack=%b g=%0d hold=%b, expected ack=1000 g=3 hold=1", f_m_ack_o, f_grant_o, f_hold);
      end
      n_vec++;
      if (f_m_data_o[96 +: 32] !== d1 || f_s_addr_o[32 +: 32] !== 32'h0000_0004) begin
         n_bad++;
         $display("FAIL prio_first_data: got data=%h addr=%h, expected data=%h addr=00000004",
                  f_m_data_o[96 +: 32], f_s_addr_o[32 +: 32], d1);
      end
      step();
      m_req[3] = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({f_m_ack_o, f_grant_o, f_hold} !== {4'b0001, 3'd0, 1'b1} || f_m_data_o[31:0] !== d1) begin
         n_bad++;
         $display("FAIL prio_second: got ack=%b g=%0d hold=%b data=%h, expected ack=0001 g=0 hold=1 data=%h",
                  f_m_ack_o, f_grant_o, f_hold, f_m_data_o[31:0], d1);
      end
      step();
      idle_inputs();
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int m = 0; m < 4; m++) set_master(m, 1'b0, 32'h2000_0000 + 32'(m * 4), 32'h0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_vec++;
         if (r_grant_o !== 3'(k % 4) || r_m_ack_o !== 4'(1 << (k % 4))) begin
            n_bad++;
            $display("FAIL rr_seq%0d: got g=%0d ack=%b, expected g=%0d", k, r_grant_o, r_m_ack_o, k % 4);
         end
         step();
      end
      idle_inputs();
   endtask

   task automatic test_ack_slave();
      do_reset();
      set_master(0, 1'b1, 32'h7000_0000, 32'h0000_00A5);
      set_master(1, 1'b0, 32'h1000_0000, 32'h0);
      @(negedge clk);
      n_vec++;
      if (f_grant_o !== 3'd0 || f_m_ack_o !== 4'b0000 || f_s_req_o !== 8'h00) begin
         n_bad++;
         $display("FAIL ack_issue: got g=%0d ack=%b sreq=%b, expected g=0 ack=0000 sreq=00", f_grant_o, f_m_ack_o, f_s_req_o);
      end
      step();
      for (int n = 1; n <= 5; n++) begin
         if (n == 5) s_ack[7] = 1'b1;
         @(negedge clk);
         n_vec++;
         if (f_s_req_o !== 8'h80 || f_s_we_o !== 8'h80 || f_s_data_o[224 +: 32] !== 32'hA5 ||
             f_s_addr_o[224 +: 32] !== 32'h0 || f_hold !== 1'b1 ||
             f_m_ack_o !== ((n == 5) ? 4'b0001 : 4'b0000)) begin
            n_bad++;
            $display("FAIL ack_wait%0d: got sreq=%b swe=%b sdata=%h hold=%b ack=%b", n,
                     f_s_req_o, f_s_we_o, f_s_data_o[224 +: 32], f_hold, f_m_ack_o);
         end
         step();
      end
      s_ack = '0;
      m_req[0] = 1'b0;
      @(negedge clk);
      n_vec++;
      if (f_s_req_o !== 8'h00 || f_m_ack_o !== 4'b0010 || f_grant_o !== 3'd1 || f_hold !== 1'b0) begin
         n_bad++;
         $display("FAIL ack_after: got sreq=%b ack=%b g=%0d hold=%b, expected 00 0010 1 0", f_s_req_o, f_m_ack_o, f_grant_o, f_hold);
      end
      step();
      idle_inputs();
   endtask

   task automatic test_timeout();
      int n;
      bit seen;
      bit err_early;
      n = 0; seen = 0; err_early = 0;
      do_reset();
      set_master(2, 1'b0, 32'h7000_0010, 32'h0);
      @(negedge clk);
      n_vec++;
      if (f_grant_o !== 3'd2 || f_m_ack_o !== 4'b0000) begin
         n_bad++;
         $display("FAIL tmo_issue: got g=%0d ack=%b, expected g=2 ack=0000", f_grant_o, f_m_ack_o);
      end
      step();
      while (!seen && n < 400) begin
         @(negedge clk);
         if (f_err) err_early = 1;
         if (f_m_ack_o[2]) seen = 1;
         else begin
            n++;
            step();
         end
      end
      n_vec++;
      if (!seen || n != 255 || f_m_data_o[64 +: 32] !== 32'h0 || err_early) begin
         n_bad++;
         $display("FAIL tmo_ack: got seen=%0d wait_cycles=%0d data=%h early_err=%0d, expected 1 255 0 0",
                  seen, n, f_m_data_o[64 +: 32], err_early);
      end
      step();
      m_req = '0;
      set_master(0, 1'b0, 32'h1000_0000, 32'h0);
      @(negedge clk);
      n_vec++;
      if (f_err !== 1'b1 || f_m_ack_o !== 4'b0001) begin
         n_bad++;
         $display("FAIL tmo_err: got err=%b ack=%b, expected err=1 ack=0001", f_err, f_m_ack_o);
      end
      step();
      m_req = '0;
      @(negedge clk);
      n_vec++;
      if (f_err !== 1'b0) begin
         n_bad++;
         $display("FAIL tmo_err_once: got err=%b, expected 0", f_err);
      end
      idle_inputs();
   endtask

   task automatic test_decode_miss();
      do_reset();
      set_master(1, 1'b0, 32'hF000_0000, 32'h0);
      @(negedge clk);
      n_vec++;
      if (f_m_ack_o !== 4'b0010 || f_m_data_o !== '0 || f_s_we_o !== 8'h0 || f_s_req_o !== 8'h0 ||
          f_err !== 1'b0 || f_hold !== 1'b0) begin
         n_bad++;
         $display("FAIL miss_rd: got ack=%b data=%h swe=%b err=%b hold=%b, expected 0010 0 00 0 0",
                  f_m_ack_o, f_m_data_o, f_s_we_o, f_err, f_hold);
      end
      step();
      m_req = '0;
      set_master(0, 1'b1, 32'hF000_0000, 32'h1234_5678);
      @(negedge clk);
      n_vec++;
      if (f_err !== 1'b1 || f_m_ack_o !== 4'b0001 || f_s_we_o !== 8'h0) begin
         n_bad++;
         $display("FAIL miss_wr: got err=%b ack=%b swe=%b, expected 1 0001 00", f_err, f_m_ack_o, f_s_we_o);
      end
      step();
      m_req = '0;
      @(negedge clk);
      n_vec++;
      if (f_err !== 1'b1) begin
         n_bad++;
         $display("FAIL miss_wr_err: got err=%b, expected 1", f_err);
      end
      idle_inputs();
   endtask

   task automatic test_reset_in_wait();
      do_reset();
      set_master(0, 1'b0, 32'h7000_0000, 32'h0);
      step();
      step();
      rst = 1'b0;
      m_req = '0;
      s_ack[7] = 1'b1;
      @(negedge clk);
      n_vec++;
      if (f_m_ack_o !== 4'b0000) begin
         n_bad++;
         $display("FAIL rstwait_noack: got ack=%b, expected 0000", f_m_ack_o);
      end
      step();
      @(negedge clk);
      n_vec++;
      if (f_s_req_o !== 8'h0 || f_m_ack_o !== 4'b0 || f_err !== 1'b0 || f_hold !== 1'b0) begin
         n_bad++;
         $display("FAIL rstwait_idle: got sreq=%b ack=%b err=%b hold=%b, expected all 0", f_s_req_o, f_m_ack_o, f_err, f_hold);
      end
      rst = 1'b1;
      idle_inputs();
   endtask

   task automatic test_random(input bit rr, input int cycles);
      int           prio[4];
      int           ptr, last_g, win, sel, cand, s;
      bit           prev_miss, miss_now, e_hold;
      logic [3:0]   e_ack, a_ack;
      logic [127:0] e_data, a_data;
      logic [7:0]   e_we, a_we, a_req;
      logic [255:0] e_addr, a_addr;
      logic [2:0]   a_g;
      logic         a_hold, a_err;
      prio = '{3, 0, 2, 1};
      ptr = 0; last_g = 0; prev_miss = 0;
      do_reset();
      for (int c = 0; c < cycles; c++) begin
         for (int m = 0; m < 4; m++) begin
            s = $urandom_range(0, 14);
            if (s >= 7) s++;
            m_req[m]            = ($urandom_range(0, 2) != 0);
            m_we[m]             = 1'($urandom_range(0, 1));
            m_addr[m*32 +: 32]  = {4'(s), 28'($urandom)};
            m_wdata[m*32 +: 32] = $urandom;
         end
         fill_sdata();
         s_ack = 8'($urandom);
         win = -1;
         for (int k = 0; k < 4; k++) begin
            cand = rr ? (ptr + k) % 4 : prio[k];
            if (win < 0 && m_req[cand]) win = cand;
         end
         e_ack = '0; e_data = '0; e_we = '0; e_addr = '0; e_hold = 0; miss_now = 0;
         if (win >= 0) begin
            sel = int'(m_addr[win*32 + 28 +: 4]);
            e_ack[win] = 1'b1;
            e_hold = (win != 1);
            last_g = win;
            ptr = (win + 1) % 4;
            if (sel >= 8) miss_now = 1;
            else begin
               e_data[win*32 +: 32] = s_rdata[sel*32 +: 32];
               e_we[sel]            = m_we[win];
               e_addr[sel*32 +: 32] = {4'h0, m_addr[win*32 +: 28]};
            end
         end
         @(negedge clk);
         a_ack  = rr ? r_m_ack_o  : f_m_ack_o;
         a_data = rr ? r_m_data_o : f_m_data_o;
         a_we   = rr ? r_s_we_o   : f_s_we_o;
         a_req  = rr ? r_s_req_o  : f_s_req_o;
         a_addr = rr ? r_s_addr_o : f_s_addr_o;
         a_g    = rr ? r_grant_o  : f_grant_o;
         a_hold = rr ? r_hold     : f_hold;
         a_err  = rr ? r_err      : f_err;
         n_vec++;
         if ({a_ack, a_g, a_hold, a_err, a_req} !== {e_ack, 3'(last_g), e_hold, prev_miss, 8'h0}) begin
            n_bad++;
            $display("FAIL rnd%0d_ctrl c%0d: got ack=%b g=%0d hold=%b err=%b sreq=%b, expected ack=%b g=%0d hold=%b err=%b sreq=00",
                     rr, c, a_ack, a_g, a_hold, a_err, a_req, e_ack, last_g, e_hold, prev_miss);
         end
         n_vec++;
         if (a_data !== e_data || a_we !== e_we || a_addr !== e_addr) begin
            n_bad++;
            $display("FAIL rnd%0d_data c%0d: got we=%b mdata=%h, expected we=%b mdata=%h", rr, c, a_we, a_data, e_we, e_data);
         end
         prev_miss = miss_now;
         step();
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      s_rdata = '0;
      test_reset();
      test_fixed_priority();
      test_round_robin();
      test_ack_slave();
      test_timeout();
      test_decode_miss();
      test_reset_in_wait();
      test_random(1'b0, 200);
      test_random(1'b1, 200);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
